// File: rtl/fs_dither_stream_unit.sv
// rtl/fs_dither_stream_unit.sv - streaming Floyd-Steinberg error-diffusion engine, one pixel per clock
// Optional DITHER_BYPASS_EN adds a per-frame dither_bypass input that turns diffusion off.
module fs_dither_stream_unit #(
    parameter int PIXEL_WIDTH = 8,
    parameter int CHANNELS    = 1,
    parameter int IMAGEX      = 64,
    parameter int IMAGEY      = 64,
    parameter int THRESHOLD   = 2**(PIXEL_WIDTH-1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
`ifdef DITHER_BYPASS_EN
    input  logic                            dither_bypass,
`endif
    input  logic                            pix_in_valid,
    output logic                            pix_in_ready,
    input  logic                            pix_in_sof,
    input  logic [CHANNELS*PIXEL_WIDTH-1:0] pix_in_data,
    output logic                            pix_out_valid,
    input  logic                            pix_out_ready,
    output logic [CHANNELS-1:0]             pix_out_data,
    output logic                            pix_out_last,
    output logic                            frame_done,
    output logic                            sof_err
);

    localparam int EW = PIXEL_WIDTH + 6;
    localparam int XW = (IMAGEX > 1) ? $clog2(IMAGEX) : 1;
    localparam int YW = (IMAGEY > 1) ? $clog2(IMAGEY) : 1;
    localparam logic [XW-1:0]          X_LAST = XW'(IMAGEX - 1);
    localparam logic [YW-1:0]          Y_LAST = YW'(IMAGEY - 1);
    localparam logic [PIXEL_WIDTH-1:0] PMAX   = '1;

    logic [XW-1:0]       r_x;
    logic [YW-1:0]       r_y;
    logic                r_out_valid;
    logic [CHANNELS-1:0] r_out_data;
    logic                r_out_last;
    logic                r_frame_done;
    logic                r_sof_err;

    logic                w_fire;
    logic                w_restart;
    logic [XW-1:0]       w_x;
    logic [YW-1:0]       w_y;
    logic                w_frame_end;
    logic                w_bypass;
    logic                w_rowadd;
    logic [CHANNELS-1:0] w_out_bits;

    assign pix_in_ready  = !r_out_valid || pix_out_ready;
    assign pix_out_valid = r_out_valid;
    assign pix_out_data  = r_out_data;
    assign pix_out_last  = r_out_last;
    assign frame_done    = r_frame_done;
    assign sof_err       = r_sof_err;

    assign w_fire      = pix_in_valid && pix_in_ready;
    // A sof anywhere but (0,0) restarts the frame: this pixel becomes (0,0) with clean error state.
    assign w_restart   = w_fire && pix_in_sof && ((r_x != '0) || (r_y != '0));
    assign w_x         = w_restart ? '0 : r_x;
    assign w_y         = w_restart ? '0 : r_y;
    assign w_frame_end = (w_x == X_LAST) && (w_y == Y_LAST);
    assign w_rowadd    = !w_bypass && (w_y != Y_LAST);

`ifdef DITHER_BYPASS_EN
    logic r_bypass;

    assign w_bypass = (w_fire && pix_in_sof) ? dither_bypass : r_bypass;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bypass <= 1'b0;
        end else if (w_fire && pix_in_sof) begin
            r_bypass <= dither_bypass;
        end
    end
`else
    assign w_bypass = 1'b0;
`endif

    genvar g;
    generate
        for (g = 0; g < CHANNELS; g++) begin : g_ch
            logic signed [EW-1:0]    r_carry;
            logic signed [EW-1:0]    r_cur [IMAGEX];
            logic signed [EW-1:0]    r_nxt [IMAGEX];
            logic signed [EW-1:0]    w_nxt_new [IMAGEX];

            logic [PIXEL_WIDTH-1:0]  w_pix;
            logic signed [EW-1:0]    w_acc;
            logic signed [EW-1:0]    w_shift;
            logic [EW:0]             w_corr;
            logic [PIXEL_WIDTH-1:0]  w_sat;
            logic                    w_bit;
            logic signed [PIXEL_WIDTH:0] w_q;
            logic signed [EW-1:0]    w_qe;
            logic signed [EW-1:0]    w_q3;
            logic signed [EW-1:0]    w_q5;
            logic signed [EW-1:0]    w_q7;
            logic signed [EW-1:0]    w_carry_nxt;

            assign w_pix   = pix_in_data[g*PIXEL_WIDTH +: PIXEL_WIDTH];
            assign w_acc   = (w_restart || w_bypass) ? '0 : r_carry + r_cur[r_x];
            assign w_shift = w_acc >>> 4;
            assign w_corr  = {{(EW+1-PIXEL_WIDTH){1'b0}}, w_pix} + {w_shift[EW-1], w_shift};
            assign w_sat   = w_corr[EW] ? '0 :
                             (|w_corr[EW-1:PIXEL_WIDTH]) ? PMAX : w_corr[PIXEL_WIDTH-1:0];
            assign w_bit   = (int'(w_sat) >= THRESHOLD);
            assign w_q     = {1'b0, w_sat} - (w_bit ? {1'b0, PMAX} : '0);
            assign w_qe    = {{(EW-PIXEL_WIDTH-1){w_q[PIXEL_WIDTH]}}, w_q};
            assign w_q3    = (w_qe <<< 1) + w_qe;
            assign w_q5    = (w_qe <<< 2) + w_qe;
            assign w_q7    = (w_qe <<< 3) - w_qe;
            assign w_carry_nxt = (w_bypass || (w_x == X_LAST)) ? '0 : w_q7;

            assign w_out_bits[g] = w_bit;

            // SW at x=0 and SE at the last column fall outside the index range and drop out.
            always_comb begin
                for (int i = 0; i < IMAGEX; i++) begin
                    w_nxt_new[i] = w_restart ? '0 : r_nxt[i];
                    if (w_rowadd) begin
                        if (i + 1 == int'(w_x)) w_nxt_new[i] = w_nxt_new[i] + w_q3;
                        if (i == int'(w_x))     w_nxt_new[i] = w_nxt_new[i] + w_q5;
                        if (i == int'(w_x) + 1) w_nxt_new[i] = w_nxt_new[i] + w_qe;
                    end
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_carry <= '0;
                    for (int i = 0; i < IMAGEX; i++) begin
                        r_cur[i] <= '0;
                        r_nxt[i] <= '0;
                    end
                end else if (w_fire) begin
                    r_carry <= w_carry_nxt;
                    for (int i = 0; i < IMAGEX; i++) begin
                        if (w_x == X_LAST) begin
                            r_cur[i] <= (w_y == Y_LAST) ? '0 : w_nxt_new[i];
                            r_nxt[i] <= '0;
                        end else begin
                            r_nxt[i] <= w_nxt_new[i];
                            if (w_restart) r_cur[i] <= '0;
                        end
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x          <= '0;
            r_y          <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_last   <= 1'b0;
            r_frame_done <= 1'b0;
            r_sof_err    <= 1'b0;
        end else begin
            r_frame_done <= r_out_valid && pix_out_ready && r_out_last;
            if (w_fire) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_out_bits;
                r_out_last  <= w_frame_end;
                if (w_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (w_y == Y_LAST) ? '0 : w_y + 1'b1;
                end else begin
                    r_x <= w_x + 1'b1;
                    r_y <= w_y;
                end
                if (w_restart) begin
                    r_sof_err <= 1'b1;
                end else if (pix_in_sof) begin
                    r_sof_err <= 1'b0;
                end
            end else if (pix_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fs_dither_stream_unit.sv
// tb/tb_fs_dither_stream_unit.sv - table-driven and scoreboard bench for fs_dither_stream_unit
module tb_fs_dither_stream_unit;

    localparam int PW = 8;
    localparam int CH = 3;
    localparam int IX = 4;
    localparam int IY = 2;
    localparam int TH = 128;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pix_in_valid;
    logic             pix_in_ready;
    logic             pix_in_sof;
    logic [CH*PW-1:0] pix_in_data;
    logic             pix_out_valid;
    logic             pix_out_ready;
    logic [CH-1:0]    pix_out_data;
    logic             pix_out_last;
    logic             frame_done;
    logic             sof_err;

    always #5 clk = ~clk;

    fs_dither_stream_unit #(
        .PIXEL_WIDTH(PW), .CHANNELS(CH), .IMAGEX(IX), .IMAGEY(IY), .THRESHOLD(TH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pix_in_valid(pix_in_valid), .pix_in_ready(pix_in_ready),
        .pix_in_sof(pix_in_sof), .pix_in_data(pix_in_data),
        .pix_out_valid(pix_out_valid), .pix_out_ready(pix_out_ready),
        .pix_out_data(pix_out_data), .pix_out_last(pix_out_last),
        .frame_done(frame_done), .sof_err(sof_err)
    );

    typedef struct {
        logic [CH*PW-1:0] pix;
        logic             sof;
        logic [CH-1:0]    exp_data;
        logic             exp_last;
    } vec_t;

    vec_t       tbl [24];
    logic [3:0] exp_q [$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_err [CH][IY][IX];
    int         m_x;
    int         m_y;
    logic       m_sof_err;
    logic       bp_on;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_clear();
        foreach (m_err[c, y, x]) m_err[c][y][x] = 0;
        m_x = 0;
        m_y = 0;
    endfunction

    // Reference keeps the whole frame's error plane; east error goes straight into the plane.
    function automatic logic [3:0] model_step(input logic [CH*PW-1:0] d, input logic sof);
        int p, acc, corr, q;
        logic [CH-1:0] bits;
        logic last;
        if (sof) begin
            if (m_x != 0 || m_y != 0) begin
                model_clear();
                m_sof_err = 1'b1;
            end else begin
                m_sof_err = 1'b0;
            end
        end
        for (int c = 0; c < CH; c++) begin
            p    = int'(d[c*PW +: PW]);
            acc  = m_err[c][m_y][m_x];
            corr = p + (acc >>> 4);
            if (corr < 0) corr = 0;
            else if (corr > 255) corr = 255;
            bits[c] = (corr >= TH);
            q = corr - (bits[c] ? 255 : 0);
            if (m_x < IX-1) m_err[c][m_y][m_x+1] += 7*q;
            if (m_y < IY-1) begin
                if (m_x > 0) m_err[c][m_y+1][m_x-1] += 3*q;
                m_err[c][m_y+1][m_x] += 5*q;
                if (m_x < IX-1) m_err[c][m_y+1][m_x+1] += q;
            end
        end
        last = (m_x == IX-1) && (m_y == IY-1);
        if (m_x == IX-1) begin
            m_x = 0;
            if (m_y == IY-1) model_clear();
            else m_y++;
        end else begin
            m_x++;
        end
        return {last, bits};
    endfunction

    task automatic send(input logic [CH*PW-1:0] d, input logic sof, input logic use_tbl,
                        input logic [3:0] texp);
        logic [3:0] mexp;
        logic acc_ok;
        acc_ok       = 1'b0;
        pix_in_valid = 1'b1;
        pix_in_data  = d;
        pix_in_sof   = sof;
        for (int k = 0; k < 50 && !acc_ok; k++) begin
            @(negedge clk);
            if (pix_in_ready) begin
                mexp = model_step(d, sof);
                exp_q.push_back(use_tbl ? texp : mexp);
                acc_ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        pix_in_valid = 1'b0;
        pix_in_sof   = 1'b0;
        chk("input_accepted", acc_ok, 1);
    endtask

    task automatic send_tbl(input int i);
        send(tbl[i].pix, tbl[i].sof, 1'b1, {tbl[i].exp_last, tbl[i].exp_data});
    endtask

    task automatic monitor();
        logic prev;
        logic [3:0] e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                chk("frame_done", frame_done, prev);
                if (pix_out_valid && pix_out_ready) begin
                    chk("out_queue_nonempty", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("out_data", pix_out_data, e[2:0]);
                        chk("out_last", pix_out_last, e[3]);
                    end
                end
                prev = pix_out_valid && pix_out_ready && pix_out_last;
            end
        end
    endtask

    initial begin
        logic [7:0] pat;
        logic [CH*PW-1:0] d;
        pat = 8'b1010_0101;
        for (int i = 0; i < 8; i++) begin
            tbl[i].pix      = {8'hFF, 8'h00, 8'h80};
            tbl[i].sof      = (i == 0);
            tbl[i].exp_data = {1'b1, 1'b0, pat[i]};
            tbl[i].exp_last = (i == 7);
            tbl[8+i].pix      = '0;
            tbl[8+i].sof      = (i == 0);
            tbl[8+i].exp_data = 3'b000;
            tbl[8+i].exp_last = (i == 7);
            tbl[16+i].pix      = '1;
            tbl[16+i].sof      = (i == 0);
            tbl[16+i].exp_data = 3'b111;
            tbl[16+i].exp_last = (i == 7);
        end

        rst_n         = 1'b0;
        pix_in_valid  = 1'b0;
        pix_in_sof    = 1'b0;
        pix_in_data   = '0;
        pix_out_ready = 1'b1;
        bp_on         = 1'b0;
        m_sof_err     = 1'b0;
        model_clear();
        fork
            monitor();
        join_none

        #2;
        chk("rst_out_valid", pix_out_valid, 0);
        chk("rst_out_data", pix_out_data, 0);
        chk("rst_out_last", pix_out_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_sof_err", sof_err, 0);
        chk("rst_in_ready", pix_in_ready, 1);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Constant frame: ch0=128, ch1=0, ch2=255, then flat 0x00 and 0xFF frames
        for (int i = 0; i < 24; i++) send_tbl(i);

        // Three-cycle downstream stall mid-row
        send_tbl(0);
        send_tbl(1);
        pix_out_ready = 1'b0;
        pix_in_valid  = 1'b1;
        pix_in_data   = tbl[2].pix;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", pix_in_ready, 0);
            chk("stall_out_valid", pix_out_valid, 1);
            chk("stall_out_data", pix_out_data, tbl[1].exp_data);
            @(posedge clk); #1;
        end
        pix_out_ready = 1'b1;
        for (int i = 2; i < 8; i++) send_tbl(i);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) send_tbl(i);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", pix_out_valid, 0);
        chk("midrst_out_data", pix_out_data, 0);
        chk("midrst_out_last", pix_out_last, 0);
        chk("midrst_in_ready", pix_in_ready, 1);
        exp_q.delete();
        model_clear();
        m_sof_err = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) send_tbl(i);

        // Misplaced sof at (2,0) restarts the frame
        send_tbl(0);
        send_tbl(1);
        send(tbl[2].pix, 1'b1, 1'b1, {tbl[0].exp_last, tbl[0].exp_data});
        chk("sof_err_set", sof_err, 1);
        for (int i = 1; i < 8; i++) send_tbl(i);
        chk("sof_err_sticky", sof_err, 1);
        send_tbl(0);
        chk("sof_err_cleared", sof_err, 0);
        for (int i = 1; i < 8; i++) send_tbl(i);

        // Random pixels, random backpressure, input gaps, one frame with no sof
        bp_on = 1'b1;
        fork
            begin
                while (bp_on) begin
                    @(posedge clk); #1;
                    pix_out_ready = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
            end
        join_none
        for (int f = 0; f < 4; f++) begin
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    @(posedge clk); #1;
                end
                d = CH*PW'($urandom);
                send(d, (i == 0) && (f != 1), 1'b0, 4'h0);
            end
        end
        bp_on = 1'b0;
        pix_out_ready = 1'b1;

        for (int k = 0; k < 200 && exp_q.size() != 0; k++) @(posedge clk);
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk); @(posedge clk); #1;
        chk("sof_err_final", sof_err, m_sof_err);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
